// File: rtl/ram_sync_param.sv
// Single-port synchronous RAM with registered read, post-reset clear and range check.
// Optional write-through echo of in-range writes: define RAM_WRITE_THROUGH_EN.
module ram_sync_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              addr_err
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

  state_t state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_nxt;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic in_range, acc, rd_ok, wr_ok, oor;
  logic [DATA_W-1:0] dout_nxt;
  logic v_nxt, e_nxt;

  assign in_range = {1'b0, addr} < LIMIT;
  assign acc = (state == READY) && mem_en;
  assign rd_ok = acc && in_range && !write_en;
  assign wr_ok = acc && in_range && write_en;
  assign oor = acc && !in_range;
  assign busy = (state == CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      clr_ptr <= clr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_nxt = clr_ptr;
    unique case (state)
      CLEAR: begin
        clr_nxt = clr_ptr + 1'b1;
        if (clr_ptr == LAST) begin
          state_nxt = READY;
          clr_nxt = '0;
        end
      end
      READY: state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    dout_nxt = data_out;
    v_nxt = 1'b0;
    e_nxt = 1'b0;
    unique case (1'b1)
      rd_ok: begin
        dout_nxt = mem[addr];
        v_nxt = 1'b1;
      end
      oor: begin
        e_nxt = 1'b1;
        if (!write_en) begin
          dout_nxt = '0;
          v_nxt = 1'b1;
        end
      end
`ifdef RAM_WRITE_THROUGH_EN
      wr_ok: begin
        dout_nxt = data_in;
        v_nxt = 1'b1;
      end
`else
      wr_ok: dout_nxt = data_out;
`endif
      default: dout_nxt = data_out;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      data_out <= dout_nxt;
      rd_valid <= v_nxt;
      addr_err <= e_nxt;
    end
  end

  // Array has no reset so it maps onto plain block RAM.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[clr_ptr] <= '0;
    else if (wr_ok)
      mem[addr] <= data_in;
  end

endmodule

// File: tb/tb_ram_sync_param.sv
// Bench for ram_sync_param: DEPTH=16 and DEPTH=10 instances checked
// against a reference model and a read-data scoreboard.
module tb_ram_sync_param;

  logic clk = 1'b0;
  logic rst;
  logic en [2];
  logic we [2];
  logic [3:0] addr [2];
  logic [7:0] din [2];
  logic [7:0] dout [2];
  logic v [2];
  logic busy [2];
  logic err [2];

  int depth [2] = '{16, 10};
  logic [7:0] mm [2][16];
  int clr_left [2];
  logic exp_v [2];
  logic exp_e [2];
  logic [7:0] exp_d [2];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_sync_param #(.DATA_W(8), .DEPTH(16)) u_a (
    .clk(clk), .rst(rst), .mem_en(en[0]), .write_en(we[0]),
    .addr(addr[0]), .data_in(din[0]), .data_out(dout[0]),
    .rd_valid(v[0]), .busy(busy[0]), .addr_err(err[0])
  );

  ram_sync_param #(.DATA_W(8), .DEPTH(10)) u_b (
    .clk(clk), .rst(rst), .mem_en(en[1]), .write_en(we[1]),
    .addr(addr[1]), .data_in(din[1]), .data_out(dout[1]),
    .rd_valid(v[1]), .busy(busy[1]), .addr_err(err[1])
  );

  task automatic chk(string tag, int i, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: got %0h expected %0h", tag, i, obs, exp);
    end
  endtask

  task automatic push(int i, logic [7:0] d);
    if (i == 0) q0.push_back(d);
    else q1.push_back(d);
  endtask

  task automatic flush(int i);
    if (i == 0) q0.delete();
    else q1.delete();
  endtask

  task automatic model_reset(int i);
    clr_left[i] = depth[i];
    exp_d[i] = 8'h00;
    exp_v[i] = 1'b0;
    exp_e[i] = 1'b0;
    flush(i);
  endtask

  // Reference behaviour for the edge about to happen.
  task automatic model(int i);
    exp_v[i] = 1'b0;
    exp_e[i] = 1'b0;
    if (rst) begin
      model_reset(i);
    end else if (clr_left[i] > 0) begin
      mm[i][depth[i] - clr_left[i]] = 8'h00;
      clr_left[i]--;
    end else if (en[i]) begin
      if (int'(addr[i]) >= depth[i]) begin
        exp_e[i] = 1'b1;
        if (!we[i]) begin
          exp_v[i] = 1'b1;
          exp_d[i] = 8'h00;
          push(i, 8'h00);
        end
      end else if (we[i]) begin
        mm[i][addr[i]] = din[i];
`ifdef RAM_WRITE_THROUGH_EN
        exp_v[i] = 1'b1;
        exp_d[i] = din[i];
        push(i, din[i]);
`endif
      end else begin
        exp_v[i] = 1'b1;
        exp_d[i] = mm[i][addr[i]];
        push(i, mm[i][addr[i]]);
      end
    end
  endtask

  task automatic check(int i);
    logic [7:0] sb;
    chk("busy", i, busy[i], clr_left[i] > 0);
    chk("rd_valid", i, v[i], exp_v[i]);
    chk("addr_err", i, err[i], exp_e[i]);
    chk("data_out", i, dout[i], exp_d[i]);
    if (v[i]) begin
      if (i == 0 && q0.size() > 0) sb = q0.pop_front();
      else if (i == 1 && q1.size() > 0) sb = q1.pop_front();
      else sb = 8'hxx;
      chk("scoreboard", i, dout[i], sb);
    end
  endtask

  task automatic step();
    model(0);
    model(1);
    @(posedge clk);
    #1;
    check(0);
    check(1);
  endtask

  task automatic acc(int i, logic e, logic w, logic [3:0] a, logic [7:0] d);
    en[i] = e;
    we[i] = w;
    addr[i] = a;
    din[i] = d;
  endtask

  task automatic idle();
    acc(0, 1'b0, 1'b0, 4'd0, 8'h00);
    acc(1, 1'b0, 1'b0, 4'd0, 8'h00);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) step();
    rst = 1'b0;

    // Clear phase; writes issued mid-clear must be dropped.
    for (int k = 0; k < 16; k++) begin
      if (k == 3) begin
        acc(0, 1'b1, 1'b1, 4'd1, 8'h3C);
        acc(1, 1'b1, 1'b1, 4'd2, 8'h3C);
      end
      step();
      idle();
    end

    for (int k = 0; k < 16; k++) begin
      acc(0, 1'b1, 1'b0, 4'(k), 8'h00);
      if (k < 10) acc(1, 1'b1, 1'b0, 4'(k), 8'h00);
      else acc(1, 1'b0, 1'b0, 4'd0, 8'h00);
      step();
    end
    idle();
    step();

    acc(0, 1'b1, 1'b1, 4'd3, 8'hA5);
    step();
    acc(0, 1'b1, 1'b0, 4'd3, 8'h00);
    step();
    idle();
    step();

    for (int k = 0; k < 10; k++) begin
      acc(1, 1'b1, 1'b1, 4'(k), 8'(k * 17 + 1));
      step();
    end
    acc(1, 1'b1, 1'b1, 4'd12, 8'hFF);
    step();
    acc(1, 1'b1, 1'b0, 4'd12, 8'h00);
    step();
    acc(1, 1'b1, 1'b0, 4'd15, 8'h00);
    step();
    for (int k = 0; k < 10; k++) begin
      acc(1, 1'b1, 1'b0, 4'(k), 8'h00);
      step();
    end
    idle();
    step();

    acc(0, 1'b1, 1'b0, 4'd3, 8'h00);
    step();
    acc(0, 1'b1, 1'b1, 4'd3, 8'h77);
    step();
    repeat (3) begin
      acc(0, 1'b1, 1'b0, 4'd3, 8'h00);
      step();
    end
    acc(0, 1'b1, 1'b0, 4'd0, 8'h00);
    step();
    idle();
    repeat (3) step();

    acc(0, 1'b1, 1'b1, 4'd2, 8'h5A);
    step();
    idle();
    repeat (3) step();

    // Reset in the middle of the clear sequence.
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (7) step();
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_dout", i, dout[i], 8'h00);
      chk("async_valid", i, v[i], 1'b0);
      chk("async_err", i, err[i], 1'b0);
      chk("async_busy", i, busy[i], 1'b1);
      model_reset(i);
    end
    step();
    rst = 1'b0;
    repeat (16) step();
    acc(0, 1'b1, 1'b0, 4'd3, 8'h00);
    acc(1, 1'b1, 1'b0, 4'd5, 8'h00);
    step();
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
